// File: rtl/fu_cfg_pkg.sv
// Shared constants and types for the FU configuration sequencer: the FU cluster
// slice widths and offsets, the sequencer state type and the stored program entry.
package fu_cfg_pkg;

    localparam int CONFIG_CMAC   = 16;
    localparam int CONFIG_CORDIC = 8;
    localparam int CONFIG_LOGI   = 9;
    localparam int CONFIG_DMEM   = 31;
    localparam int CONFIG_ALL    = CONFIG_CMAC + CONFIG_CORDIC + CONFIG_LOGI + CONFIG_DMEM;

    // Bit offsets of each FU slice inside config_all, LSB first.
    localparam int CMAC_OFS   = 0;
    localparam int CORDIC_OFS = CMAC_OFS + CONFIG_CMAC;
    localparam int LOGI_OFS   = CORDIC_OFS + CONFIG_CORDIC;
    localparam int DMEM_OFS   = LOGI_OFS + CONFIG_LOGI;

    localparam int CFG_HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic [CONFIG_ALL-1:0] word;
        logic [CFG_HOLD_W-1:0] hold;
    } cfg_entry_t;

endpackage

// File: rtl/fu_cfg_store.sv
// Program storage: register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fu_cfg_store
    import fu_cfg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  cfg_entry_t               wr_entry,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output cfg_entry_t               rd_entry
);

    cfg_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/fu_cfg_sequencer.sv
// Loads a short program of FU configuration words over valid/ready and replays it
// onto config_all, holding each word hold+1 cycles and looping the program on request.
module fu_cfg_sequencer #(
    parameter int                    CONFIG_ALL = 64,
    parameter int                    DEPTH      = 16,
    parameter int                    HOLD_W     = 8,
    parameter int                    LOOP_W     = 8,
    parameter logic [CONFIG_ALL-1:0] NOP_CFG    = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [CONFIG_ALL-1:0]      cfg_word_i,
    input  logic [HOLD_W-1:0]          cfg_hold_i,
    input  logic                       cfg_last_i,
    input  logic                       start_i,
    input  logic [LOOP_W-1:0]          loop_cnt_i,
    input  logic                       abort_i,
    output logic [CONFIG_ALL-1:0]      config_all_o,
    output logic                       cfg_strobe_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH):0]     prog_len_o
);

    import fu_cfg_pkg::*;

    localparam int AW   = $clog2(DEPTH);
    localparam int PL_W = AW + 1;

    cfg_state_e            state, state_nxt;
    logic [PL_W-1:0]       wp, wp_nxt;
    logic [PL_W-1:0]       prog_len, prog_len_nxt;
    logic [AW-1:0]         pc, pc_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
    logic [LOOP_W-1:0]     loop_cnt, loop_nxt;
    logic [CONFIG_ALL-1:0] cfg_q, cfg_nxt;
    logic                  strobe_q, strobe_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;

    logic                  beat_ok;
    logic                  start_ok;
    logic                  load_commit;
    logic                  last_pc;
    logic                  present;
    logic [AW-1:0]         wr_addr;
    cfg_entry_t            wr_entry;
    cfg_entry_t            rd_entry;

    // Handshake: a program beat transfers on a cycle where cfg_valid_i && cfg_ready_o
    // at the rising edge; ready never depends on valid, and drops while abort_i is high
    // so that an aborted cycle never transfers a beat.
    assign cfg_ready_o = !abort_i &&
                         ((state == ST_IDLE) || ((state == ST_LOAD) && (wp < PL_W'(DEPTH))));
    assign beat_ok     = cfg_valid_i && cfg_ready_o;
    assign start_ok    = (state == ST_IDLE) && start_i && !abort_i && !beat_ok &&
                         (prog_len != '0);
    assign load_commit = cfg_last_i || (wp == PL_W'(DEPTH - 1));
    assign last_pc     = (PL_W'(pc) == (prog_len - PL_W'(1)));

    assign wr_addr  = (state == ST_IDLE) ? '0 : wp[AW-1:0];
    assign wr_entry = '{word: cfg_word_i, hold: cfg_hold_i};

    // Read address is the pc being loaded this edge, so the word lands in the output register.
    fu_cfg_store #(.DEPTH(DEPTH)) u_store (
        .clk      (clk),
        .wr_en    (beat_ok),
        .wr_addr  (wr_addr),
        .wr_entry (wr_entry),
        .rd_addr  (pc_nxt),
        .rd_entry (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wp       <= '0;
            prog_len <= '0;
            pc       <= '0;
            hold_cnt <= '0;
            loop_cnt <= '0;
            cfg_q    <= NOP_CFG;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wp       <= wp_nxt;
            prog_len <= prog_len_nxt;
            pc       <= pc_nxt;
            hold_cnt <= hold_nxt;
            loop_cnt <= loop_nxt;
            cfg_q    <= cfg_nxt;
            strobe_q <= strobe_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next state, program counter and whether a new entry is presented this edge.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        present   = 1'b0;
        if (abort_i) begin
            state_nxt = ST_IDLE;
            pc_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (beat_ok) begin
                        if (!cfg_last_i) begin
                            state_nxt = ST_LOAD;
                        end
                    end else if (start_ok) begin
                        state_nxt = ST_RUN;
                        pc_nxt    = '0;
                        present   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat_ok && load_commit) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (hold_cnt == '0) begin
                        if (!last_pc) begin
                            pc_nxt  = pc + AW'(1);
                            present = 1'b1;
                        end else if (loop_cnt != '0) begin
                            pc_nxt  = '0;
                            present = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                            pc_nxt    = '0;
                        end
                    end
                end
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the load bookkeeping, counters and registered outputs.
    always_comb begin
        wp_nxt       = wp;
        prog_len_nxt = prog_len;
        hold_nxt     = hold_cnt;
        loop_nxt     = loop_cnt;
        cfg_nxt      = NOP_CFG;
        strobe_nxt   = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        if (abort_i) begin
            wp_nxt   = '0;
            hold_nxt = '0;
            loop_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (beat_ok) begin
                        prog_len_nxt = cfg_last_i ? PL_W'(1) : '0;
                        wp_nxt       = cfg_last_i ? '0 : PL_W'(1);
                    end else if (start_ok) begin
                        loop_nxt = loop_cnt_i;
                    end
                end
                ST_LOAD: begin
                    if (beat_ok) begin
                        if (load_commit) begin
                            prog_len_nxt = wp + PL_W'(1);
                            wp_nxt       = '0;
                        end else begin
                            wp_nxt = wp + PL_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                        cfg_nxt  = cfg_q;
                        busy_nxt = 1'b1;
                    end else if (last_pc) begin
                        if (loop_cnt != '0) begin
                            loop_nxt = loop_cnt - LOOP_W'(1);
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (present) begin
                cfg_nxt    = rd_entry.word;
                hold_nxt   = rd_entry.hold;
                strobe_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
        end
    end

    assign config_all_o = cfg_q;
    assign cfg_strobe_o = strobe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign prog_len_o   = prog_len;

endmodule

// File: tb/tb_fu_cfg_sequencer.sv
// Randomized scoreboard bench for fu_cfg_sequencer: a program-level model expands
// each playback into the expected per-cycle output stream, a monitor pops and compares.
module tb_fu_cfg_sequencer;

    localparam int W      = 64;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 8;
    localparam int LOOP_W = 8;
    localparam int PL_W   = 5;
    localparam int EXP_W  = W + 3;

    localparam logic [W-1:0] NOP = 64'h0;
    localparam logic [W-1:0] WA  = 64'hAAAA_0001_1111_2222;
    localparam logic [W-1:0] WB  = 64'hBBBB_0002_3333_4444;
    localparam logic [W-1:0] WC  = 64'hCCCC_0003_5555_6666;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [W-1:0]      cfg_word_i = '0;
    logic [HOLD_W-1:0] cfg_hold_i = '0;
    logic              cfg_last_i = 1'b0;
    logic              start_i = 1'b0;
    logic [LOOP_W-1:0] loop_cnt_i = '0;
    logic              abort_i = 1'b0;
    logic [W-1:0]      config_all_o;
    logic              cfg_strobe_o;
    logic              busy_o;
    logic              done_o;
    logic [PL_W-1:0]   prog_len_o;

    logic [EXP_W-1:0]  exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;

    // Program model: committed length plus the in-progress load.
    logic [W-1:0]      m_word[DEPTH];
    int                m_hold[DEPTH];
    int                m_len = 0;
    int                m_wp = 0;
    bit                m_loading = 1'b0;

    fu_cfg_sequencer #(
        .CONFIG_ALL (W),
        .DEPTH      (DEPTH),
        .HOLD_W     (HOLD_W),
        .LOOP_W     (LOOP_W),
        .NOP_CFG    (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_word_i   (cfg_word_i),
        .cfg_hold_i   (cfg_hold_i),
        .cfg_last_i   (cfg_last_i),
        .start_i      (start_i),
        .loop_cnt_i   (loop_cnt_i),
        .abort_i      (abort_i),
        .config_all_o (config_all_o),
        .cfg_strobe_o (cfg_strobe_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .prog_len_o   (prog_len_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EXP_W-1:0] mk(input bit busy, input bit done, input bit strobe,
                                            input logic [W-1:0] w);
        return {busy, done, strobe, w};
    endfunction

    task automatic check(input string name, input logic [EXP_W-1:0] act,
                         input logic [EXP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT shows busy or done, one expected beat is consumed.
    always @(negedge clk) begin
        if (rst_n && (busy_o || done_o)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none",
                         {busy_o, done_o, cfg_strobe_o, config_all_o});
            end else begin
                check("playback", {busy_o, done_o, cfg_strobe_o, config_all_o}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_accept(input logic [W-1:0] w, input int h, input bit last);
        if (!m_loading) begin
            m_wp  = 0;
            m_len = 0;
        end
        m_word[m_wp] = w;
        m_hold[m_wp] = h;
        m_wp++;
        if (last || m_wp == DEPTH) begin
            m_len     = m_wp;
            m_loading = 1'b0;
        end else begin
            m_loading = 1'b1;
        end
    endfunction

    function automatic int push_run(input int loops);
        int total = 0;
        for (int p = 0; p <= loops; p++) begin
            for (int e = 0; e < m_len; e++) begin
                for (int h = 0; h <= m_hold[e]; h++) begin
                    exp_q.push_back(mk(1'b1, 1'b0, h == 0, m_word[e]));
                    total++;
                end
            end
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, NOP));
        return total;
    endfunction

    task automatic send_beat(input logic [W-1:0] w, input int h, input bit last);
        cfg_valid_i = 1'b1;
        cfg_word_i  = w;
        cfg_hold_i  = HOLD_W'(h);
        cfg_last_i  = last;
        #1;
        check("ready", EXP_W'(cfg_ready_o), EXP_W'(1));
        tick();
        cfg_valid_i = 1'b0;
        cfg_last_i  = 1'b0;
        m_accept(w, h, last);
    endtask

    task automatic check_len(input string name);
        check(name, EXP_W'(prog_len_o), EXP_W'(m_len));
    endtask

    task automatic check_idle(input string name);
        check(name, {busy_o, done_o, cfg_strobe_o, config_all_o}, mk(1'b0, 1'b0, 1'b0, NOP));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", EXP_W'(exp_q.size()), EXP_W'(0));
        exp_q.delete();
    endtask

    task automatic run_and_check(input int loops);
        int total;
        int cyc;
        bit seen;
        total      = push_run(loops);
        start_i    = 1'b1;
        loop_cnt_i = LOOP_W'(loops);
        tick();
        start_i = 1'b0;
        check("start_latency", EXP_W'(busy_o), EXP_W'(1));
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < total + 20) begin
            tick();
            cyc++;
            seen = done_o;
        end
        check("run_len", EXP_W'(seen ? cyc : 0), EXP_W'(total + 1));
        wait_drain();
        tick();
    endtask

    task automatic load_abc();
        send_beat(WA, 0, 1'b0);
        send_beat(WB, 2, 1'b0);
        send_beat(WC, 0, 1'b1);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_out");
        check_len("reset_len");
        check("reset_ready", EXP_W'(cfg_ready_o), EXP_W'(1));
        rst_n = 1'b1;
        tick();

        // Start with no committed program does nothing.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check_idle("empty_start");

        // A, B(hold 2), C: single pass then three passes.
        load_abc();
        check_len("abc_len");
        run_and_check(0);
        check_len("abc_len_after");
        run_and_check(2);
        check_len("loop_len_after");

        // Abort during the second cycle of entry B.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, WA));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, WB));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, WB));
        start_i    = 1'b1;
        loop_cnt_i = LOOP_W'(1);
        tick();
        start_i = 1'b0;
        tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort_out");
        repeat (3) tick();
        check("abort_q", EXP_W'(exp_q.size()), EXP_W'(0));
        exp_q.delete();
        check_len("abort_len");
        run_and_check(0);

        // Beat and start together in IDLE: the beat wins.
        cfg_valid_i = 1'b1;
        cfg_word_i  = 64'h1234_5678_9ABC_DEF0;
        cfg_hold_i  = HOLD_W'(1);
        cfg_last_i  = 1'b0;
        start_i     = 1'b1;
        loop_cnt_i  = '0;
        #1;
        check("vs_ready", EXP_W'(cfg_ready_o), EXP_W'(1));
        tick();
        cfg_valid_i = 1'b0;
        start_i     = 1'b0;
        m_accept(64'h1234_5678_9ABC_DEF0, 1, 1'b0);
        check("vs_busy", EXP_W'(busy_o), EXP_W'(0));
        check_len("vs_len");
        send_beat(64'h0F0F_F0F0_0F0F_F0F0, 0, 1'b1);
        check_len("vs_len_commit");
        run_and_check(1);

        // Full-depth load without last, then a 17th beat and an abort in LOAD.
        for (int i = 0; i < DEPTH; i++) begin
            send_beat({$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
        end
        check_len("full_len");
        run_and_check(0);
        send_beat({$urandom, $urandom}, 0, 1'b0);
        check_len("reload_len");
        abort_i = 1'b1;
        tick();
        abort_i   = 1'b0;
        m_loading = 1'b0;
        check_len("load_abort_len");
        check_idle("load_abort_out");

        // Random programs and loop counts.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) begin
                send_beat({$urandom, $urandom}, $urandom_range(0, 3),
                          (i == len - 1) && ((len < DEPTH) || ($urandom_range(0, 1) == 1)));
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                end
            end
            check_len("rand_len");
            run_and_check($urandom_range(0, 2));
        end

        // Reset in the middle of a run discards the program.
        load_abc();
        void'(push_run(2));
        start_i    = 1'b1;
        loop_cnt_i = LOOP_W'(2);
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_idle("rst_out");
        check("rst_len", EXP_W'(prog_len_o), EXP_W'(0));
        check("rst_ready", EXP_W'(cfg_ready_o), EXP_W'(1));
        exp_q.delete();
        rst_n     = 1'b1;
        m_len     = 0;
        m_loading = 1'b0;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check_idle("rst_start");
        check_len("rst_len_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
